// File: rtl/microsequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer_pkg
// Description : Shared definitions for the microsequencer:
//               - state codes (6-bit, also exported on STATE)
//               - control-word (CW) field bit positions and field encodings
//               - ARM condition code constants
//               - instruction class constants (IR[27:25])
// Revision    : 1.0  initial release
// ============================================================================
package microsequencer_pkg;

  // --------------------------------------------------------------------------
  // State codes. Gaps in the numbering are unused codes that recover to RST.
  // --------------------------------------------------------------------------
  typedef enum logic [5:0] {
    ST_RST     = 6'd0,
    ST_F1      = 6'd1,
    ST_F2      = 6'd2,
    ST_F3      = 6'd3,
    ST_DEC     = 6'd4,
    ST_DP      = 6'd5,
    ST_LS_ADDR = 6'd10,
    ST_LD_MEM  = 6'd11,
    ST_LD_WB   = 6'd12,
    ST_ST_MDR  = 6'd13,
    ST_ST_MEM  = 6'd14,
    ST_BL_LINK = 6'd20,
    ST_BR      = 6'd21
  } state_t;

  // --------------------------------------------------------------------------
  // CW single-bit control positions
  // --------------------------------------------------------------------------
  localparam int c_cw_mfa     = 31;
  localparam int c_cw_rw_ram  = 30;
  localparam int c_cw_salu    = 29;
  localparam int c_cw_rf_rw   = 28;
  localparam int c_cw_ssab    = 27;
  localparam int c_cw_ssop    = 26;
  localparam int c_cw_sma     = 25;
  localparam int c_cw_sta     = 24;
  localparam int c_cw_mar_en  = 23;
  localparam int c_cw_sr_en   = 22;
  localparam int c_cw_mdr_en  = 21;
  localparam int c_cw_ir_en   = 20;
  localparam int c_cw_sht_en  = 19;
  localparam int c_cw_ise_en  = 18;
  localparam int c_cw_sgn_en  = 17;
  localparam int c_cw_dp_clr  = 16;

  // CW multi-bit field positions
  localparam int c_cw_dss_hi   = 15;
  localparam int c_cw_dss_lo   = 14;
  localparam int c_cw_wra_hi   = 13;
  localparam int c_cw_wra_lo   = 12;
  localparam int c_cw_sra_hi   = 11;
  localparam int c_cw_sra_lo   = 10;
  localparam int c_cw_srb_hi   = 9;
  localparam int c_cw_srb_lo   = 8;
  localparam int c_cw_sise_hi  = 7;
  localparam int c_cw_sise_lo  = 6;
  localparam int c_cw_salub_hi = 5;
  localparam int c_cw_salub_lo = 4;
  localparam int c_cw_alua_hi  = 3;
  localparam int c_cw_alua_lo  = 0;

  // --------------------------------------------------------------------------
  // CW field encodings understood by the data path
  // --------------------------------------------------------------------------
  // DSS: register-file write data source
  localparam logic [1:0] c_dss_alu   = 2'b00;
  localparam logic [1:0] c_dss_mdr   = 2'b01;
  localparam logic [1:0] c_dss_pc    = 2'b10;
  // WRA: register-file write address select
  localparam logic [1:0] c_wra_rd    = 2'b00;
  localparam logic [1:0] c_wra_lr    = 2'b01;
  localparam logic [1:0] c_wra_pc    = 2'b10;
  // SRA / SRB: register-file read port selects
  localparam logic [1:0] c_sr_rn     = 2'b00;
  localparam logic [1:0] c_sr_rd     = 2'b01;
  localparam logic [1:0] c_sr_rm     = 2'b10;
  localparam logic [1:0] c_sr_pc     = 2'b11;
  // SISE: immediate extender format
  localparam logic [1:0] c_sise_i12  = 2'b00;
  localparam logic [1:0] c_sise_i24  = 2'b10;
  // SALUB: ALU B operand source
  localparam logic [1:0] c_salub_sht = 2'b00;
  localparam logic [1:0] c_salub_imm = 2'b01;
  localparam logic [1:0] c_salub_k4  = 2'b10;
  // ALUA: ALU operation (ARM data-processing opcode numbering)
  localparam logic [3:0] c_alu_sub   = 4'b0010;
  localparam logic [3:0] c_alu_add   = 4'b0100;
  localparam logic [3:0] c_alu_mov   = 4'b1101;

  // --------------------------------------------------------------------------
  // ARM condition codes (IR[31:28])
  // --------------------------------------------------------------------------
  localparam logic [3:0] c_cond_eq = 4'h0;
  localparam logic [3:0] c_cond_ne = 4'h1;
  localparam logic [3:0] c_cond_cs = 4'h2;
  localparam logic [3:0] c_cond_cc = 4'h3;
  localparam logic [3:0] c_cond_mi = 4'h4;
  localparam logic [3:0] c_cond_pl = 4'h5;
  localparam logic [3:0] c_cond_vs = 4'h6;
  localparam logic [3:0] c_cond_vc = 4'h7;
  localparam logic [3:0] c_cond_hi = 4'h8;
  localparam logic [3:0] c_cond_ls = 4'h9;
  localparam logic [3:0] c_cond_ge = 4'hA;
  localparam logic [3:0] c_cond_lt = 4'hB;
  localparam logic [3:0] c_cond_gt = 4'hC;
  localparam logic [3:0] c_cond_le = 4'hD;
  localparam logic [3:0] c_cond_al = 4'hE;
  localparam logic [3:0] c_cond_nv = 4'hF;

  // --------------------------------------------------------------------------
  // Instruction classes (IR[27:25])
  // --------------------------------------------------------------------------
  localparam logic [2:0] c_cls_dp_reg = 3'b000;
  localparam logic [2:0] c_cls_dp_imm = 3'b001;
  localparam logic [2:0] c_cls_ls_imm = 3'b010;
  localparam logic [2:0] c_cls_ls_reg = 3'b011;
  localparam logic [2:0] c_cls_branch = 3'b101;

endpackage : microsequencer_pkg
`default_nettype wire

// File: rtl/microsequencer_cond_eval.sv
`default_nettype none
// ============================================================================
// Module      : cond_eval
// Description : Combinational ARM condition-code evaluator.
// Ports       : cond  [3:0] in  condition field (IR[31:28])
//               FLAGS [3:0] in  status {N,Z,C,V}
//               pass        out 1 = condition holds
// Revision    : 1.0  initial release
// ============================================================================
module cond_eval
  import microsequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] FLAGS,
  output logic       pass
);

  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign w_n = FLAGS[3];
  assign w_z = FLAGS[2];
  assign w_c = FLAGS[1];
  assign w_v = FLAGS[0];

  always_comb begin
    pass = 1'b0;
    case (cond)
      c_cond_eq: pass = w_z;
      c_cond_ne: pass = ~w_z;
      c_cond_cs: pass = w_c;
      c_cond_cc: pass = ~w_c;
      c_cond_mi: pass = w_n;
      c_cond_pl: pass = ~w_n;
      c_cond_vs: pass = w_v;
      c_cond_vc: pass = ~w_v;
      c_cond_hi: pass = w_c & ~w_z;
      c_cond_ls: pass = ~w_c | w_z;
      c_cond_ge: pass = (w_n == w_v);
      c_cond_lt: pass = (w_n != w_v);
      c_cond_gt: pass = ~w_z & (w_n == w_v);
      c_cond_le: pass = w_z | (w_n != w_v);
      c_cond_al: pass = 1'b1;
      // 1111 is treated as "never" rather than the ARMv5+ unconditional space
      c_cond_nv: pass = 1'b0;
      default:   pass = 1'b0;
    endcase
  end

endmodule : cond_eval
`default_nettype wire

// File: rtl/microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : microsequencer
// Description : Moore-style hardwired control unit for a small ARM-like data
//               path: fetch / decode / data-processing / load / store /
//               branch(-link) sequencing with memory wait states.
// Ports       : CLK         in  clock (rising edge)
//               CLR         in  asynchronous active-low reset
//               IR    [31:0] in  instruction register
//               MFC         in  memory-function-complete
//               FLAGS [3:0]  in  status {N,Z,C,V}
//               CW    [31:0] out control word to the data path
//               STATE [5:0]  out current state code (debug)
// Revision    : 1.0  initial release
// ============================================================================
module microsequencer
  import microsequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  FLAGS,
  output logic [31:0] CW,
  output logic [5:0]  STATE
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] w_cw;
  logic        w_cond_pass;
  logic        w_unused_ir;

  // Operand/offset fields are consumed by the data path, not the sequencer.
  assign w_unused_ir = ^IR[19:0];

  cond_eval u_cond_eval (
    .cond  (IR[31:28]),
    .FLAGS (FLAGS),
    .pass  (w_cond_pass)
  );

  // --------------------------------------------------------------------------
  // State register. The reset is asynchronous so that an abort during a
  // memory wait drops MFA combinationally, without waiting for a clock.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= ST_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic and control store
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = ST_RST;
    w_cw         = '0;

    case (r_state)
      ST_RST: begin
        w_next_state        = ST_F1;
        w_cw[c_cw_dp_clr]   = 1'b1;
      end

      // MAR <- PC
      ST_F1: begin
        w_next_state                        = ST_F2;
        w_cw[c_cw_mar_en]                   = 1'b1;
        w_cw[c_cw_sra_hi:c_cw_sra_lo]       = c_sr_pc;
        w_cw[c_cw_alua_hi:c_cw_alua_lo]     = c_alu_mov;
      end

      // Instruction read; MDR captures RAM data while waiting for MFC
      ST_F2: begin
        w_next_state        = MFC ? ST_F3 : ST_F2;
        w_cw[c_cw_mfa]      = 1'b1;
        w_cw[c_cw_rw_ram]   = 1'b1;
        w_cw[c_cw_mdr_en]   = 1'b1;
      end

      // IR <- MDR, PC <- PC + 4
      ST_F3: begin
        w_next_state                        = ST_DEC;
        w_cw[c_cw_ir_en]                    = 1'b1;
        w_cw[c_cw_rf_rw]                    = 1'b1;
        w_cw[c_cw_salu]                     = 1'b1;
        w_cw[c_cw_wra_hi:c_cw_wra_lo]       = c_wra_pc;
        w_cw[c_cw_sra_hi:c_cw_sra_lo]       = c_sr_pc;
        w_cw[c_cw_salub_hi:c_cw_salub_lo]   = c_salub_k4;
        w_cw[c_cw_alua_hi:c_cw_alua_lo]     = c_alu_add;
      end

      ST_DEC: begin
        if (!w_cond_pass) begin
          w_next_state = ST_F1;
        end else begin
          case (IR[27:25])
            c_cls_dp_reg, c_cls_dp_imm: w_next_state = ST_DP;
            c_cls_ls_imm, c_cls_ls_reg: w_next_state = ST_LS_ADDR;
            c_cls_branch:               w_next_state = IR[24] ? ST_BL_LINK : ST_BR;
            default:                    w_next_state = ST_F1;
          endcase
        end
      end

      // Rd <- Rn op shifter. IR is stable during execute, so the opcode,
      // S bit and operand type are taken straight from it.
      ST_DP: begin
        w_next_state                        = ST_F1;
        w_cw[c_cw_rf_rw]                    = 1'b1;
        w_cw[c_cw_salu]                     = 1'b1;
        w_cw[c_cw_sht_en]                   = 1'b1;
        w_cw[c_cw_ssop]                     = IR[25];
        w_cw[c_cw_sr_en]                    = IR[20];
        w_cw[c_cw_wra_hi:c_cw_wra_lo]       = c_wra_rd;
        w_cw[c_cw_sra_hi:c_cw_sra_lo]       = c_sr_rn;
        w_cw[c_cw_srb_hi:c_cw_srb_lo]       = c_sr_rm;
        w_cw[c_cw_salub_hi:c_cw_salub_lo]   = c_salub_sht;
        w_cw[c_cw_alua_hi:c_cw_alua_lo]     = IR[24:21];
      end

      // MAR <- Rn +/- offset (U bit IR[23] picks the direction)
      ST_LS_ADDR: begin
        w_next_state                        = IR[20] ? ST_LD_MEM : ST_ST_MDR;
        w_cw[c_cw_mar_en]                   = 1'b1;
        w_cw[c_cw_ise_en]                   = 1'b1;
        w_cw[c_cw_sise_hi:c_cw_sise_lo]     = c_sise_i12;
        w_cw[c_cw_sra_hi:c_cw_sra_lo]       = c_sr_rn;
        w_cw[c_cw_salub_hi:c_cw_salub_lo]   = c_salub_imm;
        w_cw[c_cw_alua_hi:c_cw_alua_lo]     = IR[23] ? c_alu_add : c_alu_sub;
      end

      ST_LD_MEM: begin
        w_next_state        = MFC ? ST_LD_WB : ST_LD_MEM;
        w_cw[c_cw_mfa]      = 1'b1;
        w_cw[c_cw_rw_ram]   = 1'b1;
        w_cw[c_cw_mdr_en]   = 1'b1;
      end

      // Rd <- MDR
      ST_LD_WB: begin
        w_next_state                        = ST_F1;
        w_cw[c_cw_rf_rw]                    = 1'b1;
        w_cw[c_cw_wra_hi:c_cw_wra_lo]       = c_wra_rd;
        w_cw[c_cw_dss_hi:c_cw_dss_lo]       = c_dss_mdr;
      end

      // MDR <- Rd, routed over the B read port
      ST_ST_MDR: begin
        w_next_state                        = ST_ST_MEM;
        w_cw[c_cw_mdr_en]                   = 1'b1;
        w_cw[c_cw_ssab]                     = 1'b1;
        w_cw[c_cw_srb_hi:c_cw_srb_lo]       = c_sr_rd;
      end

      // Write cycle: RW_RAM stays 0
      ST_ST_MEM: begin
        w_next_state        = MFC ? ST_F1 : ST_ST_MEM;
        w_cw[c_cw_mfa]      = 1'b1;
      end

      // R14 <- PC
      ST_BL_LINK: begin
        w_next_state                        = ST_BR;
        w_cw[c_cw_rf_rw]                    = 1'b1;
        w_cw[c_cw_wra_hi:c_cw_wra_lo]       = c_wra_lr;
        w_cw[c_cw_dss_hi:c_cw_dss_lo]       = c_dss_pc;
      end

      // PC <- PC + (sext(IR[23:0]) << 2)
      ST_BR: begin
        w_next_state                        = ST_F1;
        w_cw[c_cw_rf_rw]                    = 1'b1;
        w_cw[c_cw_salu]                     = 1'b1;
        w_cw[c_cw_ise_en]                   = 1'b1;
        w_cw[c_cw_sgn_en]                   = 1'b1;
        w_cw[c_cw_sise_hi:c_cw_sise_lo]     = c_sise_i24;
        w_cw[c_cw_wra_hi:c_cw_wra_lo]       = c_wra_pc;
        w_cw[c_cw_sra_hi:c_cw_sra_lo]       = c_sr_pc;
        w_cw[c_cw_salub_hi:c_cw_salub_lo]   = c_salub_imm;
        w_cw[c_cw_alua_hi:c_cw_alua_lo]     = c_alu_add;
      end

      // Unused codes recover through RST
      default: begin
        w_next_state = ST_RST;
      end
    endcase
  end

  assign CW    = w_cw;
  assign STATE = r_state;

endmodule : microsequencer
`default_nettype wire

// File: tb/tb_microsequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_microsequencer
// Description : Self-checking bench for microsequencer. Stimulus pushes the
//               expected STATE and masked CW for each cycle into a scoreboard
//               queue; a monitor on the falling edge pops and compares.
// Revision    : 1.0  initial release
// ============================================================================
module tb_microsequencer;

  localparam logic [31:0] M_ALL   = 32'hFFFF_FFFF;
  localparam logic [31:0] M_MFA   = 32'h8000_0000;
  localparam logic [31:0] M_RW    = 32'h4000_0000;
  localparam logic [31:0] M_RF    = 32'h1000_0000;
  localparam logic [31:0] M_MAR   = 32'h0080_0000;
  localparam logic [31:0] M_SR    = 32'h0040_0000;
  localparam logic [31:0] M_MDR   = 32'h0020_0000;
  localparam logic [31:0] M_IR    = 32'h0010_0000;
  localparam logic [31:0] CW_RST  = 32'h0001_0000;

  logic        CLK;
  logic        CLR;
  logic [31:0] IR;
  logic        MFC;
  logic [3:0]  FLAGS;
  logic [31:0] CW;
  logic [5:0]  STATE;

  typedef struct {
    int          cyc;
    logic [5:0]  st;
    logic [31:0] mask;
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  microsequencer dut (
    .CLK   (CLK),
    .CLR   (CLR),
    .IR    (IR),
    .MFC   (MFC),
    .FLAGS (FLAGS),
    .CW    (CW),
    .STATE (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: sample on the falling edge, away from the active edge
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      total = total + 1;
      if (mon_e.cyc != cyc || STATE !== mon_e.st || (CW & mon_e.mask) !== mon_e.val) begin
        bad = bad + 1;
        $display("FAIL %s cyc=%0d: got STATE=%0d CW=%h, want STATE=%0d CW&%h=%h",
                 mon_e.nm, cyc, STATE, CW, mon_e.st, mon_e.mask, mon_e.val);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_cyc(input logic [5:0] st, input logic [31:0] mask,
                            input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc  = cyc;
    e.st   = st;
    e.mask = mask;
    e.val  = val;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  // One cycle: expect the state/CW now, drive MFC for the edge that ends it
  task automatic step(input logic [5:0] st, input logic mfc, input logic [31:0] mask,
                      input logic [31:0] val, input string nm);
    tick();
    MFC = mfc;
    expect_cyc(st, mask, val, nm);
  endtask

  // F1, n_f2 cycles of F2 (MFC raised in the last), F3, DEC
  task automatic fetch(input logic [31:0] ir, input logic [3:0] fl,
                       input logic mfc_f1, input int n_f2);
    step(6'd1, mfc_f1, M_MFA | M_MAR, M_MAR, "f1");
    IR    = ir;
    FLAGS = fl;
    for (int i = 0; i < n_f2; i++)
      step(6'd2, (i == n_f2 - 1), M_MFA | M_RW, M_MFA | M_RW, "f2");
    step(6'd3, 1'b0, M_MFA | M_IR, M_IR, "f3");
    step(6'd4, 1'b0, M_MFA, 32'h0, "dec");
  endtask

  initial begin
    IR    = 32'h0;
    MFC   = 1'b0;
    FLAGS = 4'h0;
    CLR   = 1'b1;
    #1 CLR = 1'b0;

    // Reset and first fetch; EQ with Z=0 fails back to F1
    step(6'd0, 1'b0, M_ALL, CW_RST, "rst_cw");
    step(6'd0, 1'b0, M_ALL, CW_RST, "rst_hold");
    CLR = 1'b1;
    fetch(32'h0000_0000, 4'b0000, 1'b1, 1);

    // Five F2 wait cycles, then AL data-processing without S
    fetch(32'hE000_0000, 4'b0000, 1'b0, 5);
    step(6'd5, 1'b0, M_MFA | M_RF | M_SR, M_RF, "dp_nos");

    // Data-processing with S: SR_EN follows IR[20]
    fetch(32'hE010_0000, 4'b0000, 1'b0, 1);
    step(6'd5, 1'b0, M_MFA | M_RF | M_SR, M_RF | M_SR, "dp_s");

    // NE with Z=1 fails
    fetch(32'h1000_0000, 4'b0100, 1'b0, 1);
    // GT with all flags clear passes
    fetch(32'hC000_0000, 4'b0000, 1'b0, 2);
    step(6'd5, 1'b0, M_RF, M_RF, "dp_gt");
    // LT with N=V fails
    fetch(32'hB000_0000, 4'b1001, 1'b0, 1);
    // Class 100 is a NOP
    fetch(32'hE800_0000, 4'b0000, 1'b0, 1);

    // Branch with link
    fetch(32'hEB00_0002, 4'b0000, 1'b0, 1);
    step(6'd20, 1'b0, M_MFA | M_RF, M_RF, "bl_link");
    step(6'd21, 1'b0, M_MFA | M_RF, M_RF, "br");
    // Condition 1111 never executes
    fetch(32'hFA00_0000, 4'b0000, 1'b0, 1);

    // LDR: stale MFC=1 from LS_ADDR lets LD_MEM advance at once
    fetch(32'hE591_2000, 4'b0000, 1'b0, 1);
    step(6'd10, 1'b1, M_MFA | M_MAR, M_MAR, "ls_addr_ld");
    step(6'd11, 1'b1, M_MFA | M_RW, M_MFA | M_RW, "ld_mem");
    step(6'd12, 1'b0, M_MFA | M_RF, M_RF, "ld_wb");

    // STR with one ST_MEM wait cycle
    fetch(32'hE581_2000, 4'b0000, 1'b0, 1);
    step(6'd10, 1'b0, M_MFA | M_MAR, M_MAR, "ls_addr_st");
    step(6'd13, 1'b0, M_MFA | M_MDR, M_MDR, "st_mdr");
    step(6'd14, 1'b0, M_MFA | M_RW, M_MFA, "st_mem_wait");
    step(6'd14, 1'b1, M_MFA | M_RW, M_MFA, "st_mem");

    // Asynchronous abort while waiting in LD_MEM
    fetch(32'hE591_2000, 4'b0000, 1'b0, 1);
    step(6'd10, 1'b0, M_MFA | M_MAR, M_MAR, "ls_addr_ld2");
    step(6'd11, 1'b0, M_MFA | M_RW, M_MFA | M_RW, "ld_mem_wait");
    tick();
    CLR = 1'b0;
    #1;
    expect_cyc(6'd0, M_ALL, CW_RST, "abort_ld_mem");
    step(6'd0, 1'b0, M_ALL, CW_RST, "abort_hold");
    CLR = 1'b1;
    step(6'd1, 1'b0, M_MFA | M_MAR, M_MAR, "post_abort_f1");
    step(6'd2, 1'b1, M_MFA | M_RW, M_MFA | M_RW, "post_abort_f2");

    // Every pushed expectation must have been consumed by the monitor
    repeat (2) tick();
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL scoreboard_drain: pending=%0d want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_microsequencer
`default_nettype wire
